dmem_access_ctrl: RTL and testbench

- Load/store access controller between the MEM pipeline stage and the 32-bit byte-lane data RAM.
- Accepts one load or store request at a time over a valid/ready handshake and generates the RAM chip-enable, write-enable, byte-select, word address and lane-replicated write data.
- Captures the RAM's combinational read data and returns an extracted, sign- or zero-extended load result over a valid/ready response handshake.
- Flags misaligned accesses without touching the RAM.

---
 rtl/dmem_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Load/store access controller between the MEM pipeline stage and a 32-bit
// byte-lane data RAM. One request is in flight at a time.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_op                0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW
//   req_addr, req_wdata   byte address, right-justified store data
//   resp_valid/resp_ready response handshake
//   resp_rdata, resp_err  extended load result (0 for stores/errors), misalign
//   ram_ce, ram_we        RAM chip enable / write enable
//   ram_sel               byte enables, sel[3] -> data[31:24] (big-endian lanes)
//   ram_addr, ram_wdata   word-aligned address, lane-replicated write data
//   ram_rdata             combinational RAM read data
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [2:0] {
    OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                req_misaligned;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [DATA_W-1:0]   load_val;

  // Alignment of the incoming request; byte operations are always aligned.
  always_comb begin
    req_misaligned = 1'b0;
    case (op_e'(req_op))
      OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
      OP_LW, OP_SW:         req_misaligned = |req_addr[1:0];
      default:              req_misaligned = 1'b0;
    endcase
  end

  // Big-endian lane extraction: byte offset 0 lives in data[31:24].
  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte = ram_rdata[31:24];
      2'd1:    rd_byte = ram_rdata[23:16];
      2'd2:    rd_byte = ram_rdata[15:8];
      default: rd_byte = ram_rdata[7:0];
    endcase
    rd_half = addr_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
  end

  always_comb begin
    case (op_q)
      OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_val = {24'h0, rd_byte};
      OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_val = {16'h0, rd_half};
      OP_LW:   load_val = ram_rdata;
      default: load_val = '0;
    endcase
  end

  // Next-state and outputs. RAM outputs are decoded from the state register,
  // so an asynchronous reset drops them in the same instant.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_sel    = 4'b0000;
    ram_addr   = '0;
    ram_wdata  = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op_e'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_misaligned;
          // A misaligned request skips the RAM entirely.
          state_d = req_misaligned ? RESP : ACCESS;
        end
      end

      ACCESS: begin
        ram_ce   = 1'b1;
        ram_we   = op_q inside {OP_SB, OP_SH, OP_SW};
        ram_addr = {addr_q[ADDR_W-1:2], 2'b00};
        case (op_q)
          OP_LB, OP_LBU: ram_sel = 4'b1000 >> addr_q[1:0];
          OP_SB: begin
            ram_sel   = 4'b1000 >> addr_q[1:0];
            ram_wdata = {4{wdata_q[7:0]}};
          end
          OP_LH, OP_LHU: ram_sel = addr_q[1] ? 4'b0011 : 4'b1100;
          OP_SH: begin
            ram_sel   = addr_q[1] ? 4'b0011 : 4'b1100;
            ram_wdata = {2{wdata_q[15:0]}};
          end
          OP_SW: begin
            ram_sel   = 4'b1111;
            ram_wdata = wdata_q;
          end
          default: ram_sel = 4'b1111;
        endcase
        rdata_d = load_val;
        err_d   = 1'b0;
        state_d = RESP;
      end

      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_ce;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Environment RAM: 64 words, combinational read, byte-enabled write.
  logic [31:0] ram [64] = '{default: 32'h0};
  assign ram_rdata = ram[ram_addr[7:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_sel[i]) ram[ram_addr[7:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
  end

  // Reference model: flat byte-addressed memory, big-endian multi-byte values.
  logic [7:0] ref_mem [256] = '{default: 8'h0};

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd5: return 1;
      3'd2, 3'd3, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic logic model_misal(input logic [2:0] op, input logic [31:0] a);
    return (a % op_size(op)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
    logic [7:0] i;
    i = a[7:0];
    case (op)
      3'd0: return {{24{ref_mem[i][7]}}, ref_mem[i]};
      3'd1: return {24'h0, ref_mem[i]};
      3'd2: return {{16{ref_mem[i][7]}}, ref_mem[i], ref_mem[i+8'd1]};
      3'd3: return {16'h0, ref_mem[i], ref_mem[i+8'd1]};
      3'd4: return {ref_mem[i], ref_mem[i+8'd1], ref_mem[i+8'd2], ref_mem[i+8'd3]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = op_size(op);
    for (int j = 0; j < n; j++)
      ref_mem[a[7:0] + 8'(j)] = wd[8*(n-1-j) +: 8];
  endtask

  function automatic logic [3:0] model_sel(input logic [2:0] op, input logic [31:0] a);
    logic [3:0] s;
    s = 4'b0000;
    for (int j = 0; j < op_size(op); j++) s[3 - ((a + j) % 4)] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    if (op < 3'd5) return 32'h0;
    n = op_size(op);
    r = 32'h0;
    for (int j = 0; j < 4 / n; j++)
      r = r | ((wd & (n == 4 ? 32'hFFFF_FFFF : (32'h1 << (8*n)) - 32'h1)) << (8*n*j));
    return r;
  endfunction

  typedef struct {
    bit          accepted;
    int          lat;
    int          ce_cycles;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wd;
    logic [31:0] ram_a;
    logic [31:0] rdata;
    logic        err;
    bit          stable;
    bit          ready_low;
    bit          ready_after;
  } obs_t;

  task automatic scramble();
    req_valid = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Issue one request, observe the RAM side and the response, hold the
  // response for `hold` cycles, then release it.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input int hold, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    o.accepted = req_ready;
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      if (ram_ce) begin
        o.ce_cycles++;
        o.sel   = ram_sel;
        o.we    = ram_we;
        o.wd    = ram_wdata;
        o.ram_a = ram_addr;
      end
      if (resp_valid) begin
        o.lat = i;
        break;
      end
      scramble();
      @(negedge clk);
    end
    o.rdata     = resp_rdata;
    o.err       = resp_err;
    o.stable    = 1'b1;
    o.ready_low = (req_ready === 1'b0);
    for (int h = 0; h < hold; h++) begin
      scramble();
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== o.rdata || resp_err !== o.err) o.stable = 1'b0;
      if (req_ready !== 1'b0) o.ready_low = 1'b0;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready    = 1'b0;
    o.ready_after = (req_ready === 1'b1) && (resp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; resp_ready = 1'b0;
    #3;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'h0)
      begin errors++; $display("FAIL reset_resp: got v=%b e=%b d=%h expected zeros", resp_valid, resp_err, resp_rdata); end
    checks++;
    if ({ram_ce, ram_we, ram_sel, ram_addr, ram_wdata} !== 70'h0)
      begin errors++; $display("FAIL reset_ram: got ce=%b we=%b sel=%b a=%h wd=%h expected zeros", ram_ce, ram_we, ram_sel, ram_addr, ram_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    obs_t o;
    run_txn(3'd7, 32'h10, 32'hA1B2C3D4, 0, o);
    model_store(3'd7, 32'h10, 32'hA1B2C3D4);
    checks++;
    if (o.sel !== 4'b1111 || o.we !== 1'b1 || o.ce_cycles != 1)
      begin errors++; $display("FAIL sw_access: got sel=%b we=%b ce_cycles=%0d expected 1111 1 1", o.sel, o.we, o.ce_cycles); end
    run_txn(3'd4, 32'h10, 32'h0, 0, o);
    checks++;
    if (o.rdata !== 32'hA1B2C3D4 || o.err !== 1'b0)
      begin errors++; $display("FAIL lw_data: got %h err=%b expected a1b2c3d4 err=0", o.rdata, o.err); end
    checks++;
    if (o.lat != 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", o.lat); end
  endtask

  task automatic test_byte();
    obs_t o;
    run_txn(3'd5, 32'h21, 32'h000000F0, 0, o);
    model_store(3'd5, 32'h21, 32'h000000F0);
    checks++;
    if (o.sel !== 4'b0100 || o.wd !== 32'hF0F0F0F0)
      begin errors++; $display("FAIL sb_lanes: got sel=%b wd=%h expected 0100 f0f0f0f0", o.sel, o.wd); end
    run_txn(3'd0, 32'h21, 32'h0, 0, o);
    checks++;
    if (o.rdata !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_sext: got %h expected fffffff0", o.rdata); end
    run_txn(3'd1, 32'h21, 32'h0, 0, o);
    checks++;
    if (o.rdata !== 32'h000000F0) begin errors++; $display("FAIL lbu_zext: got %h expected 000000f0", o.rdata); end
  endtask

  task automatic test_half();
    obs_t o;
    run_txn(3'd6, 32'h32, 32'h00008001, 0, o);
    model_store(3'd6, 32'h32, 32'h00008001);
    checks++;
    if (o.sel !== 4'b0011 || o.wd !== 32'h80018001)
      begin errors++; $display("FAIL sh_lanes: got sel=%b wd=%h expected 0011 80018001", o.sel, o.wd); end
    run_txn(3'd2, 32'h32, 32'h0, 0, o);
    checks++;
    if (o.rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sext: got %h expected ffff8001", o.rdata); end
    run_txn(3'd3, 32'h32, 32'h0, 0, o);
    checks++;
    if (o.rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_zext: got %h expected 00008001", o.rdata); end
    run_txn(3'd4, 32'h30, 32'h0, 0, o);
    checks++;
    if (o.rdata !== model_load(3'd4, 32'h30))
      begin errors++; $display("FAIL lw_upper_half: got %h expected %h", o.rdata, model_load(3'd4, 32'h30)); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_txn(3'd4, 32'h13, 32'h0, 0, o);
    checks++;
    if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.ce_cycles != 0 || o.lat != 1)
      begin errors++; $display("FAIL lw_misal: got err=%b d=%h ce=%0d lat=%0d expected 1 0 0 1", o.err, o.rdata, o.ce_cycles, o.lat); end
    run_txn(3'd6, 32'h41, 32'h0000BEEF, 0, o);
    checks++;
    if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.ce_cycles != 0 || o.lat != 1)
      begin errors++; $display("FAIL sh_misal: got err=%b d=%h ce=%0d lat=%0d expected 1 0 0 1", o.err, o.rdata, o.ce_cycles, o.lat); end
    run_txn(3'd4, 32'h40, 32'h0, 0, o);
    checks++;
    if (o.rdata !== model_load(3'd4, 32'h40))
      begin errors++; $display("FAIL misal_no_write: got %h expected %h", o.rdata, model_load(3'd4, 32'h40)); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_txn(3'd4, 32'h10, 32'h0, 5, o);
    checks++;
    if (o.rdata !== model_load(3'd4, 32'h10) || o.err !== 1'b0)
      begin errors++; $display("FAIL bp_data: got %h err=%b expected %h err=0", o.rdata, o.err, model_load(3'd4, 32'h10)); end
    checks++;
    if (!o.stable || !o.ready_low)
      begin errors++; $display("FAIL bp_hold: got stable=%0b ready_low=%0b expected 1 1", o.stable, o.ready_low); end
    checks++;
    if (!o.ready_after) begin errors++; $display("FAIL bp_release: got ready_after=%0b expected 1", o.ready_after); end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h50; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #2;
    checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b1)
      begin errors++; $display("FAIL rst_pre_access: got ce=%b we=%b expected 1 1", ram_ce, ram_we); end
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if (ram_ce !== 1'b0 || ram_we !== 1'b0 || resp_valid !== 1'b0)
      begin errors++; $display("FAIL rst_async_drop: got ce=%b we=%b rv=%b expected 0 0 0", ram_ce, ram_we, resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_no_resp: got %0d bad cycles expected 0", seen); end
    run_txn(3'd4, 32'h50, 32'h0, 0, o);
    checks++;
    if (o.rdata !== model_load(3'd4, 32'h50))
      begin errors++; $display("FAIL rst_no_write: got %h expected %h", o.rdata, model_load(3'd4, 32'h50)); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [2:0]  op;
    logic [31:0] a, wd, exp_rd;
    logic        exp_err;
    int          hold;
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(op_size(op)) - 32'h1);
      wd   = $urandom;
      hold = $urandom_range(0, 2);
      exp_err = model_misal(op, a);
      exp_rd  = (op < 3'd5 && !exp_err) ? model_load(op, a) : 32'h0;
      run_txn(op, a, wd, hold, o);
      if (op >= 3'd5 && !exp_err) model_store(op, a, wd);
      checks++;
      if (o.accepted !== 1'b1 || o.err !== exp_err || o.rdata !== exp_rd)
        begin errors++; $display("FAIL rnd_resp op=%0d a=%h: got acc=%0b err=%b d=%h expected 1 %b %h", op, a, o.accepted, o.err, o.rdata, exp_err, exp_rd); end
      checks++;
      if (o.lat != (exp_err ? 1 : 2) || o.ce_cycles != (exp_err ? 0 : 1))
        begin errors++; $display("FAIL rnd_timing op=%0d a=%h: got lat=%0d ce=%0d expected %0d %0d", op, a, o.lat, o.ce_cycles, exp_err ? 1 : 2, exp_err ? 0 : 1); end
      if (!exp_err) begin
        checks++;
        if (o.sel !== model_sel(op, a) || o.we !== (op >= 3'd5) || o.wd !== model_wdata(op, wd) || o.ram_a !== (a & 32'hFFFF_FFFC))
          begin errors++; $display("FAIL rnd_ram op=%0d a=%h: got sel=%b we=%b wd=%h ra=%h expected %b %b %h %h", op, a, o.sel, o.we, o.wd, o.ram_a, model_sel(op, a), op >= 3'd5, model_wdata(op, wd), a & 32'hFFFF_FFFC); end
      end
      checks++;
      if (!o.stable || !o.ready_low || !o.ready_after)
        begin errors++; $display("FAIL rnd_handshake op=%0d a=%h: got stable=%0b low=%0b after=%0b expected 1 1 1", op, a, o.stable, o.ready_low, o.ready_after); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
